custom_axi_regs: RTL and testbench
==================================

# custom_axi_regs

AXI4-Lite responder that gives software register access to the `custom_axi_ip` core. It drives the core's register-to-hardware inputs (`din`, `enable_in`) and captures its outputs (`dout`, `enable_out`, `status_out`) into readable registers. It sits between the interconnect and the core, one instance per core.

## Interface
- `ADDR_WIDTH`, 4: AXI address width; bits [3:2] select the register, bits [1:0] are ignored.
- `DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `s_awaddr` in ADDR_WIDTH, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in ADDR_WIDTH, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `din` out 32: operand to the core; this is the DIN register.
- `enable_in` out 1: start pulse to the core.
- `dout` in 33: core result, {data[31:0], valid}.
- `enable_out` in 2: core output enable; bit 0 marks a result.
- `status_i` in 2: core state code (IDLE=0, BUSY=1, DONE=2, ERROR=3).

## Operation
- Register map:
  - 0x0 CTRL, W: bit0 START. Writing 1 pulses `enable_in`. Reads return 0.
  - 0x4 DIN, RW: byte-wise `s_wstrb` applies.
  - 0x8 RESULT, RO: last captured `dout[32:1]`.
  - 0xC STATUS:
    - bit0 DONE: sticky, write-1-to-clear.
    - bit1 OVERRUN: sticky, write-1-to-clear.
    - bits[3:2]: live `status_i`.
    - All other bits read 0.
- Writes to RO registers and to the unused bits of a register are ignored. Their response is OKAY.
- Addresses are fully decoded within ADDR_WIDTH, so every address maps to a register and `bresp`/`rresp` are always OKAY (2'b00). SLVERR is unused.
- Write path:
  - AW and W are accepted independently, in either order, into one holding slot each.
  - `s_awready` = AW slot empty. `s_wready` = W slot empty.
  - When both slots are full and `s_bvalid` is low, the write commits. The same edge clears both slots and sets `s_bvalid`.
  - `s_bvalid` holds until `s_bready`.
- Read path:
  - `s_arready` = !`s_rvalid`.
  - An AR handshake registers `s_rdata` and sets `s_rvalid`.
  - `s_rdata` holds stable until `s_rready`.
- Capture: when `enable_out[0]` && `dout[0]`:
  - RESULT <= `dout[32:1]`.
  - DONE <= 1.
  - If DONE was already 1, OVERRUN <= 1.
- Simultaneous capture and DONE W1C on the same edge: capture wins, DONE stays 1. OVERRUN follows the pre-edge DONE value.
- A START write that also sets DIN is impossible: they are separate addresses. Software writes DIN first, then CTRL.
- START writes while `status_i` != IDLE still pulse `enable_in`. The core decides whether to act on it.

## Timing
- Reset values:
  - `s_awready`, `s_wready`, `s_arready` = 1.
  - `s_bvalid`, `s_rvalid` = 0.
  - `s_bresp`, `s_rresp`, `s_rdata` = 0.
  - `din` = 0, `enable_in` = 0, RESULT = 0, DONE = 0, OVERRUN = 0.
- Reset asserted mid-transaction discards held AW/W slots and pending B/R responses immediately, with no completion.
- Write latency:
  - Last of the AW/W handshakes at edge N: commit and `s_bvalid`=1 after edge N+1. Register update is visible at the same point.
  - If AW and W handshake together at edge N, the result is the same.
- `enable_in` is high for exactly the one cycle following the commit edge.
- Back-to-back writes: the next AW/W may be accepted while B is pending. The commit waits for `s_bready`. Maximum throughput is one write per 2 cycles.
- Read latency: AR handshake at edge N gives `s_rvalid`=1 after edge N. Throughput is one read per 2 cycles.
- STATUS[3:2] are sampled at the AR handshake edge.
- Capture happens at the edge where the `enable_out`/`dout` condition is true. It is visible to a read whose AR handshake occurs at the next edge or later.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle -> all outputs take their reset values immediately. Then reads of 0x4/0x8/0xC return 0.
- DIN write with strobes:
  - Write 0x4 = 0xDEADBEEF, `wstrb`=4'hF -> `din`=0xDEADBEEF.
  - Then write 0x4 = 0x00000011 with `wstrb`=4'h1 -> `din`=0xDEADBE11.
  - `bresp`=OKAY for both.
- W-before-AW ordering: present W 3 cycles ahead of AW -> `s_wready` drops after the W handshake, and the commit occurs 1 cycle after the AW handshake.
- End-to-end with a core model:
  - Write DIN=0x5, then CTRL=1 -> one-cycle `enable_in`.
  - Core returns `dout`={0x6,1} with `enable_out`=1 -> RESULT reads 0x6, STATUS bit0=1.
  - Write STATUS=1 -> DONE clears.
- Overrun and collision:
  - Two captures without a clear -> OVERRUN=1.
  - A capture on the same edge as the DONE W1C -> DONE remains 1.
- Backpressure: hold `s_rready`=0 for 5 cycles -> `s_rdata`/`s_rvalid` stable, `s_arready`=0. Hold `s_bready`=0 -> `s_bvalid` stays high and a second write does not commit.

Source files
------------

// File: rtl/custom_axi_regs_if.sv
// AXI4-Lite bus bundle for custom_axi_regs; the interconnect side is the master.
interface custom_axi_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input s_rdata, s_rresp, s_rvalid, output s_rready
  );

  modport slave (
    input s_awaddr, s_awvalid, output s_awready,
    input s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );
endinterface

// File: rtl/custom_axi_regs.sv
// AXI4-Lite register file for custom_axi_ip: CTRL/DIN drive the core, RESULT/STATUS
// capture its output. AW and W each have a one-entry holding slot.
module custom_axi_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  custom_axi_regs_if.slave      s,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  enable_in,
  input  logic [DATA_WIDTH:0]   dout,
  input  logic [1:0]            enable_out,
  input  logic [1:0]            status_i
);
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIN    = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int         NBYTES     = DATA_WIDTH / 8;

  logic                  aw_full_q, aw_full_d;
  logic [1:0]            aw_sel_q, aw_sel_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NBYTES-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  enable_in_q, enable_in_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  logic commit;
  logic capture;
  logic unused_bits;

  assign commit  = aw_full_q && w_full_q && !bvalid_q;
  assign capture = enable_out[0] && dout[0];

  always_comb begin
    aw_full_d   = aw_full_q;
    aw_sel_d    = aw_sel_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    din_d       = din_q;
    enable_in_d = 1'b0;
    result_d    = result_q;
    done_d      = done_q;
    overrun_d   = overrun_q;

    if (s.s_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_sel_d  = s.s_awaddr[3:2];
    end
    if (s.s_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s.s_wdata;
      w_strb_d = s.s_wstrb;
    end

    if (bvalid_q && s.s_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (aw_sel_q)
        REG_CTRL: enable_in_d = w_strb_q[0] && w_data_q[0];
        REG_DIN: begin
          for (int b = 0; b < NBYTES; b++) begin
            if (w_strb_q[b]) din_d[8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        REG_STATUS: begin
          if (w_strb_q[0] && w_data_q[0]) done_d    = 1'b0;
          if (w_strb_q[0] && w_data_q[1]) overrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Capture is evaluated after the W1C so a same-edge result keeps DONE set.
    if (capture) begin
      result_d = dout[DATA_WIDTH:1];
      done_d   = 1'b1;
      if (done_q) overrun_d = 1'b1;
    end

    if (s.s_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      case (s.s_araddr[3:2])
        REG_DIN:    rdata_d = din_q;
        REG_RESULT: rdata_d = result_q;
        REG_STATUS: rdata_d = {{(DATA_WIDTH-4){1'b0}}, status_i, overrun_q, done_q};
        default:    rdata_d = '0;
      endcase
    end else if (rvalid_q && s.s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q   <= 1'b0;
      aw_sel_q    <= 2'd0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      din_q       <= '0;
      enable_in_q <= 1'b0;
      result_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_sel_q    <= aw_sel_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      din_q       <= din_d;
      enable_in_q <= enable_in_d;
      result_q    <= result_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign s.s_awready = !aw_full_q;
  assign s.s_wready  = !w_full_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = 2'b00;
  assign s.s_arready = !rvalid_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = 2'b00;
  assign din         = din_q;
  assign enable_in   = enable_in_q;

  // Byte-offset address bits and enable_out[1] carry no meaning here.
  assign unused_bits = ^{s.s_awaddr, s.s_araddr, enable_out[1]};
endmodule

// File: tb/tb_custom_axi_regs.sv
// Self-checking bench for custom_axi_regs: vector table plus hand-written
// sequences for ordering, capture collisions, backpressure and async reset.
module tb_custom_axi_regs;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] din;
  logic        enable_in;
  logic [32:0] dout = '0;
  logic [1:0]  enable_out = '0;
  logic [1:0]  status_i = '0;

  custom_axi_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  custom_axi_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s          (axi.slave),
    .din        (din),
    .enable_in  (enable_in),
    .dout       (dout),
    .enable_out (enable_out),
    .status_i   (status_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // din after a write, rdata for a read
  } vec_t;

  vec_t        vecs[10];
  logic [1:0]  b_exp[$];
  logic [31:0] r_exp[$];
  int          total = 0;
  int          bad = 0;
  logic        en_s, en_a;
  logic [31:0] e;
  logic [31:0] st;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] sb,
                           output logic en_seen, output logic en_after);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    logic [1:0] eb;
    aw_done = 0; w_done = 0; en_seen = 0; en_after = 0;
    axi.s_awaddr = a; axi.s_awvalid = 1'b1;
    axi.s_wdata = d; axi.s_wstrb = sb; axi.s_wvalid = 1'b1;
    axi.s_bready = 1'b1;
    b_exp.push_back(2'b00);
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = axi.s_awvalid && axi.s_awready;
      hs_w  = axi.s_wvalid && axi.s_wready;
      tick;
      n++;
      if (hs_aw) begin aw_done = 1; axi.s_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  axi.s_wvalid = 1'b0; end
    end
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("aw_w_timeout", 32'd0, 32'd1);
      b_exp.delete();
      return;
    end
    n = 0;
    while (!axi.s_bvalid && n < 20) begin tick; n++; end
    if (!axi.s_bvalid) begin
      chk("b_timeout", 32'd0, 32'd1);
      b_exp.delete();
      return;
    end
    en_seen = enable_in;
    eb = b_exp.pop_front();
    chk("bresp", {30'd0, axi.s_bresp}, {30'd0, eb});
    tick;
    en_after = enable_in;
    $display("wr addr=%h data=%h strb=%h din=%h", a, d, sb, din);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    bit hs;
    int n;
    logic [31:0] ex;
    r_exp.push_back(exp);
    axi.s_araddr = a; axi.s_arvalid = 1'b1; axi.s_rready = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 20) begin hs = axi.s_arready; tick; n++; end
    axi.s_arvalid = 1'b0;
    if (!hs) begin chk("ar_timeout", 32'd0, 32'd1); r_exp.delete(); return; end
    n = 0;
    while (!axi.s_rvalid && n < 20) begin tick; n++; end
    if (!axi.s_rvalid) begin chk("r_timeout", 32'd0, 32'd1); r_exp.delete(); return; end
    ex = r_exp.pop_front();
    chk("rdata", axi.s_rdata, ex);
    chk("rresp", {30'd0, axi.s_rresp}, 32'd0);
    $display("rd addr=%h rdata=%h exp=%h", a, axi.s_rdata, ex);
    tick;
  endtask

  task automatic pulse_capture(input logic [31:0] d);
    dout = {d, 1'b1};
    enable_out = 2'b01;
    tick;
    dout = '0;
    enable_out = 2'b00;
  endtask

  initial begin
    axi.s_awaddr = '0; axi.s_awvalid = 0; axi.s_wdata = '0; axi.s_wstrb = '0;
    axi.s_wvalid = 0; axi.s_bready = 0; axi.s_araddr = '0; axi.s_arvalid = 0;
    axi.s_rready = 0;

    vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'h4, 32'h00000011, 4'h1, 32'hDEADBE11};
    vecs[2] = '{1'b0, 4'h4, 32'h0,        4'h0, 32'hDEADBE11};
    vecs[3] = '{1'b1, 4'h5, 32'hAABBCCDD, 4'hC, 32'hAABBBE11};
    vecs[4] = '{1'b0, 4'h6, 32'h0,        4'h0, 32'hAABBBE11};
    vecs[5] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h00000000};
    vecs[6] = '{1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 32'hAABBBE11};
    vecs[7] = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h00000000};
    vecs[8] = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h00000008};
    vecs[9] = '{1'b1, 4'h4, 32'h00000005, 4'hF, 32'h00000005};

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_awready", {31'd0, axi.s_awready}, 32'd1);
    chk("rst_wready",  {31'd0, axi.s_wready},  32'd1);
    chk("rst_arready", {31'd0, axi.s_arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, axi.s_bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, axi.s_rvalid},  32'd0);
    chk("rst_din",     din, 32'd0);
    rst_i = 1'b0;
    status_i = 2'd2;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, en_s, en_a);
        chk("vec_din", din, vecs[i].exp);
      end else begin
        axi_read(vecs[i].addr, vecs[i].exp);
      end
    end

    // End-to-end: DIN=5 then START; core model returns din+1
    st = 32'd1 << 2;
    status_i = 2'd1;
    axi_write(4'h0, 32'h1, 4'hF, en_s, en_a);
    chk("start_pulse", {31'd0, en_s}, 32'd1);
    chk("start_pulse_end", {31'd0, en_a}, 32'd0);
    axi_write(4'h0, 32'h0, 4'hF, en_s, en_a);
    chk("start_zero", {31'd0, en_s}, 32'd0);
    pulse_capture(32'h5 + 32'h1);
    axi_read(4'h8, 32'h6);
    axi_read(4'hC, st | 32'h1);
    axi_write(4'hC, 32'h1, 4'hF, en_s, en_a);
    axi_read(4'hC, st);

    // Overrun: two captures without a clear
    status_i = 2'd3;
    st = 32'd3 << 2;
    pulse_capture(32'hA);
    axi_read(4'hC, st | 32'h1);
    pulse_capture(32'hB);
    axi_read(4'hC, st | 32'h3);
    axi_read(4'h8, 32'hB);
    axi_write(4'hC, 32'h2, 4'hF, en_s, en_a);
    axi_read(4'hC, st | 32'h1);

    // Capture on the same edge as the DONE W1C commit
    axi.s_awaddr = 4'hC; axi.s_awvalid = 1'b1;
    axi.s_wdata = 32'h1; axi.s_wstrb = 4'hF; axi.s_wvalid = 1'b1; axi.s_bready = 1'b0;
    b_exp.push_back(2'b00);
    tick;
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    dout = {32'h77, 1'b1}; enable_out = 2'b01;
    tick;
    dout = '0; enable_out = 2'b00;
    chk("coll_bvalid", {31'd0, axi.s_bvalid}, 32'd1);
    chk("coll_bresp", {30'd0, axi.s_bresp}, {30'd0, b_exp.pop_front()});
    axi.s_bready = 1'b1;
    tick;
    $display("collision W1C+capture done");
    axi_read(4'hC, st | 32'h3);
    axi_read(4'h8, 32'h77);

    // W presented three cycles ahead of AW
    axi.s_wdata = 32'h12345678; axi.s_wstrb = 4'hF; axi.s_wvalid = 1'b1; axi.s_bready = 1'b1;
    b_exp.push_back(2'b00);
    tick;
    axi.s_wvalid = 1'b0;
    chk("wfirst_wready", {31'd0, axi.s_wready}, 32'd0);
    tick;
    tick;
    chk("wfirst_nobvalid", {31'd0, axi.s_bvalid}, 32'd0);
    axi.s_awaddr = 4'h4; axi.s_awvalid = 1'b1;
    tick;
    axi.s_awvalid = 1'b0;
    chk("wfirst_hs_bvalid", {31'd0, axi.s_bvalid}, 32'd0);
    chk("wfirst_hs_din", din, 32'h00000005);
    tick;
    chk("wfirst_commit_bvalid", {31'd0, axi.s_bvalid}, 32'd1);
    chk("wfirst_commit_din", din, 32'h12345678);
    chk("wfirst_bresp", {30'd0, axi.s_bresp}, {30'd0, b_exp.pop_front()});
    tick;
    $display("wr W-before-AW din=%h", din);

    // Read backpressure: rdata/rvalid hold, no new AR accepted
    axi.s_rready = 1'b0;
    axi.s_araddr = 4'h4; axi.s_arvalid = 1'b1;
    r_exp.push_back(32'h12345678);
    tick;
    axi.s_araddr = 4'h8;
    e = r_exp.pop_front();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rvalid", {31'd0, axi.s_rvalid}, 32'd1);
      chk("bp_arready", {31'd0, axi.s_arready}, 32'd0);
      chk("bp_rdata", axi.s_rdata, e);
      tick;
    end
    axi.s_arvalid = 1'b0; axi.s_rready = 1'b1;
    tick;
    chk("bp_rvalid_drop", {31'd0, axi.s_rvalid}, 32'd0);
    $display("rd backpressure rdata=%h", e);

    // Write backpressure: second write waits for bready
    axi.s_bready = 1'b0;
    axi.s_awaddr = 4'h4; axi.s_awvalid = 1'b1;
    axi.s_wdata = 32'h11111111; axi.s_wvalid = 1'b1;
    tick;
    axi.s_wdata = 32'h22222222;
    tick;
    chk("bpw_bvalid1", {31'd0, axi.s_bvalid}, 32'd1);
    chk("bpw_din1", din, 32'h11111111);
    tick;
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    repeat (3) begin
      tick;
      chk("bpw_bvalid_hold", {31'd0, axi.s_bvalid}, 32'd1);
      chk("bpw_no_commit", din, 32'h11111111);
    end
    axi.s_bready = 1'b1;
    tick;
    chk("bpw_bvalid_low", {31'd0, axi.s_bvalid}, 32'd0);
    tick;
    chk("bpw_bvalid2", {31'd0, axi.s_bvalid}, 32'd1);
    chk("bpw_din2", din, 32'h22222222);
    tick;
    $display("wr backpressure din=%h", din);

    // Asynchronous reset mid-cycle with AW held and R pending
    status_i = 2'd0;
    axi.s_awaddr = 4'h4; axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b0;
    axi.s_araddr = 4'h4; axi.s_arvalid = 1'b1; axi.s_rready = 1'b0;
    tick;
    chk("pre_rst_awready", {31'd0, axi.s_awready}, 32'd0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_awready", {31'd0, axi.s_awready}, 32'd1);
    chk("arst_wready",  {31'd0, axi.s_wready},  32'd1);
    chk("arst_arready", {31'd0, axi.s_arready}, 32'd1);
    chk("arst_rvalid",  {31'd0, axi.s_rvalid},  32'd0);
    chk("arst_rdata",   axi.s_rdata, 32'd0);
    chk("arst_bvalid",  {31'd0, axi.s_bvalid},  32'd0);
    chk("arst_din",     din, 32'd0);
    chk("arst_enable",  {31'd0, enable_in}, 32'd0);
    axi.s_awvalid = 1'b0; axi.s_arvalid = 1'b0;
    tick;
    rst_i = 1'b0;
    tick;
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", total);
    $fatal(1, "timeout");
  end
endmodule
